// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: funct3 size codes,
// response-slot states and the byte-enable / load-extension helpers.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

    function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_B, SZ_BU: be = 4'b0001 << lane;
            SZ_H, SZ_HU: be = 4'b0011 << lane;
            SZ_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Shift the addressed byte/half down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] size,
                                             input logic [1:0] lane);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_B:    res = {{24{sh[7]}}, sh[7:0]};
            SZ_H:    res = {{16{sh[15]}}, sh[15:0]};
            SZ_W:    res = sh;
            SZ_BU:   res = {24'h0, sh[7:0]};
            SZ_HU:   res = {16'h0, sh[15:0]};
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// Request/response bus of the byte-lane data memory.
// With DMEM_PARITY_EN defined the bus also carries par_inject.
interface dmem_bytelane_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_PARITY_EN
    logic        par_inject;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready, par_inject,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready, par_inject,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
`endif
endinterface

// File: rtl/dmem_ram_be.sv
// DEPTH-word RAM with four independently enabled write lanes of LANE_W bits
// and a registered read port that holds its value while re is low.
module dmem_ram_be #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned LANE_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [4*LANE_W-1:0]      wdata,
    input  logic                     re,
    output logic [4*LANE_W-1:0]      rdata
);

    logic [4*LANE_W-1:0] mem [DEPTH];
    logic [4*LANE_W-1:0] rdata_q;
    logic [4*LANE_W-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_bytelane.sv
// RV32I data memory: byte-lane stores, extended loads, fault flagging and a
// one-entry back-pressurable response slot. Optional macro: DMEM_PARITY_EN.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    dmem_bytelane_if.slave bus
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
`ifdef DMEM_PARITY_EN
    localparam int unsigned LANE_W = 9;
`else
    localparam int unsigned LANE_W = 8;
`endif

    logic                rsp_valid;
    logic                req_ready;
    logic                accept;
    logic [31:0]         off;
    logic [1:0]          lane;
    logic [AW-1:0]       index;
    logic                req_err;
    logic [3:0]          be;
    logic [31:0]         wdata_rep;
    logic                ram_we;
    logic                ram_re;
    logic [4*LANE_W-1:0] ram_wdata;
    logic [4*LANE_W-1:0] ram_rdata;
    logic [31:0]         rd_word;
    logic [31:0]         ext_data;
    logic                any_err;

    slot_state_t state_q, state_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic        load_q, load_d;
    logic        err_q, err_d;

    assign rsp_valid = (state_q == SLOT_FULL);
    assign req_ready = !rsp_valid || bus.rsp_ready;
    assign accept    = bus.req_valid && req_ready;

    always_comb begin
        off     = bus.req_addr - BASE_ADDR;
        lane    = off[1:0];
        index   = off[AW+1:2];
        req_err = 1'b0;
        if (off >= SPAN) begin
            req_err = 1'b1;
        end
        case (bus.req_size)
            SZ_B, SZ_BU: ;
            SZ_H, SZ_HU: if (lane[0]) req_err = 1'b1;
            SZ_W:        if (lane != 2'b00) req_err = 1'b1;
            default:     req_err = 1'b1;
        endcase
        if (bus.req_we && bus.req_size[2]) begin
            req_err = 1'b1;
        end
        be = be_gen(bus.req_size, lane);
        case (bus.req_size[1:0])
            2'b00:   wdata_rep = {4{bus.req_wdata[7:0]}};
            2'b01:   wdata_rep = {2{bus.req_wdata[15:0]}};
            default: wdata_rep = bus.req_wdata;
        endcase
    end

    // Faulted requests and anything arriving during reset never touch the RAM.
    assign ram_we = accept && !rst && bus.req_we && !req_err;
    assign ram_re = accept && !rst && !bus.req_we && !req_err;

    always_comb begin
        ram_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            ram_wdata[i*LANE_W +: 8] = wdata_rep[i*8 +: 8];
`ifdef DMEM_PARITY_EN
            ram_wdata[i*LANE_W + 8] = (^wdata_rep[i*8 +: 8]) ^ bus.par_inject;
`endif
        end
    end

    dmem_ram_be #(
        .DEPTH  (DEPTH),
        .LANE_W (LANE_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (be),
        .addr  (index),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        lane_d  = lane_q;
        load_d  = load_q;
        err_d   = err_q;
        if (accept) begin
            size_d = bus.req_size;
            lane_d = lane;
            load_d = !bus.req_we;
            err_d  = req_err;
        end
        case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL:  if (bus.rsp_ready && !accept) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            size_q  <= 3'b000;
            lane_q  <= 2'b00;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    // A parity fault still returns the extended data; only address/size faults zero it.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            rd_word[i*8 +: 8] = ram_rdata[i*LANE_W +: 8];
        end
        ext_data = load_ext(rd_word, size_q, lane_q);
        any_err  = err_q;
`ifdef DMEM_PARITY_EN
        for (int i = 0; i < 4; i++) begin
            if (load_q && be_gen(size_q, lane_q)[i] && (^ram_rdata[i*LANE_W +: LANE_W])) begin
                any_err = 1'b1;
            end
        end
`endif
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = (rsp_valid && load_q && !err_q) ? ext_data : 32'h0;
    assign bus.rsp_err   = rsp_valid && any_err;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: directed vector table, back-pressure and reset
// sequences, then randomized traffic checked against a byte-array model.
module tb_dmem_bytelane;
    import dmem_pkg::*;

    localparam int unsigned DEPTH     = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int unsigned SPAN      = DEPTH * 4;

    logic clk = 1'b0;
    logic rst;

    dmem_bytelane_if bus();

    dmem_bytelane #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    logic [7:0] mem_model [SPAN];
    rsp_t       exp_q [$];
    vec_t       vecs [$];

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive_req(input bit v, input bit we, input logic [31:0] addr,
                             input logic [2:0] size, input logic [31:0] wdata);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_wdata = wdata;
    endtask

    task automatic add_vec(input bit we, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // Single isolated request: drive at a falling edge, check one cycle later.
    task automatic apply_stimulus(input vec_t v, input string name);
        drive_req(1'b1, v.we, v.addr, v.size, v.wdata);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_output({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check_output({name, "_rdata"}, bus.rsp_rdata, v.exp_rdata);
        check_output({name, "_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    endtask

    task automatic idle_cycle();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference behaviour: little-endian byte array, faults from alignment/size/range rules.
    function automatic rsp_t model_access(input bit we, input logic [31:0] addr,
                                          input logic [2:0] size, input logic [31:0] wdata);
        rsp_t        r;
        logic [31:0] off;
        logic [31:0] val;
        int          n;
        bit          sgn;
        off = addr - BASE_ADDR;
        n = 0;
        sgn = 1'b0;
        case (size)
            3'b000: begin n = 1; sgn = 1'b1; end
            3'b001: begin n = 2; sgn = 1'b1; end
            3'b010: begin n = 4; sgn = 1'b0; end
            3'b100: begin n = 1; sgn = 1'b0; end
            3'b101: begin n = 2; sgn = 1'b0; end
            default: n = 0;
        endcase
        r.rdata = 32'h0;
        r.err   = 1'b0;
        if (n == 0 || off >= SPAN || (we && size[2]) || (off % n != 0)) begin
            r.err = 1'b1;
            return r;
        end
        if (we) begin
            for (int i = 0; i < n; i++) mem_model[off + i] = wdata[8*i +: 8];
        end else begin
            val = 32'h0;
            for (int i = 0; i < n; i++) val = val | (32'(mem_model[off + i]) << (8 * i));
            if (sgn && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
            r.rdata = val;
        end
        return r;
    endfunction

    // One scoreboard cycle; entered and left at a falling edge.
    task automatic run_cycle(input bit v, input bit we, input logic [31:0] addr,
                             input logic [2:0] size, input logic [31:0] wdata, input bit rr);
        bit   exp_ready;
        rsp_t r;
        check_output("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0 && bus.rsp_valid) begin
            check_output("rnd_rdata", bus.rsp_rdata, exp_q[0].rdata);
            check_output("rnd_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
        end
        drive_req(v, we, addr, size, wdata);
        bus.rsp_ready = rr;
        #1;
        exp_ready = (exp_q.size() == 0) || rr;
        check_output("rnd_req_ready", 32'(bus.req_ready), 32'(exp_ready));
        if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
        if (v && exp_ready) begin
            r = model_access(we, addr, size, wdata);
            exp_q.push_back(r);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [2:0]  legal_sz [5];
        logic [2:0]  sz;
        logic [31:0] addr;
        bit          we;
        vec_t        v;

        legal_sz = '{SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
        rst = 1'b1;
        drive_req(1'b0, 1'b0, 32'h0, SZ_W, 32'h0);
        bus.rsp_ready = 1'b0;
`ifdef DMEM_PARITY_EN
        bus.par_inject = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("rst_rdata", bus.rsp_rdata, 32'h0);
        check_output("rst_err", 32'(bus.rsp_err), 32'd0);
        check_output("rst_req_ready", 32'(bus.req_ready), 32'd1);

        add_vec(1, 32'h10, SZ_W,  32'hDEADBEEF, 32'h0000_0000, 0);
        add_vec(0, 32'h10, SZ_W,  32'h0,        32'hDEADBEEF, 0);
        add_vec(1, 32'h13, SZ_B,  32'h0000_0080, 32'h0000_0000, 0);
        add_vec(0, 32'h13, SZ_B,  32'h0,        32'hFFFFFF80, 0);
        add_vec(0, 32'h13, SZ_BU, 32'h0,        32'h0000_0080, 0);
        add_vec(0, 32'h10, SZ_W,  32'h0,        32'h80ADBEEF, 0);
        add_vec(0, 32'h11, SZ_H,  32'h0,        32'h0000_0000, 1);
        add_vec(1, 32'h12, SZ_W,  32'h1111_1111, 32'h0000_0000, 1);
        add_vec(0, 32'h10, SZ_W,  32'h0,        32'h80ADBEEF, 0);
        add_vec(0, 32'h10, 3'b011, 32'h0,       32'h0000_0000, 1);
        add_vec(1, 32'h10, 3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        add_vec(0, 32'h400, SZ_W, 32'h0,        32'h0000_0000, 1);
        add_vec(1, 32'h400, SZ_W, 32'h5555_5555, 32'h0000_0000, 1);
        add_vec(1, 32'h10, SZ_BU, 32'h0,        32'h0000_0000, 1);
        add_vec(0, 32'h10, SZ_W,  32'h0,        32'h80ADBEEF, 0);
        add_vec(1, 32'h14, SZ_W,  32'h11223344, 32'h0000_0000, 0);
        add_vec(1, 32'h16, SZ_H,  32'h12348001, 32'h0000_0000, 0);
        add_vec(0, 32'h14, SZ_W,  32'h0,        32'h80013344, 0);
        add_vec(0, 32'h16, SZ_H,  32'h0,        32'hFFFF8001, 0);
        add_vec(0, 32'h16, SZ_HU, 32'h0,        32'h0000_8001, 0);
        add_vec(0, 32'h15, SZ_B,  32'h0,        32'h0000_0033, 0);
        add_vec(0, 32'h14, SZ_H,  32'h0,        32'h0000_3344, 0);
        add_vec(0, 32'hFFFF_FFFC, SZ_W, 32'h0,  32'h0000_0000, 1);
        add_vec(0, 32'h14, 3'b111, 32'h0,       32'h0000_0000, 1);
        add_vec(0, 32'h17, SZ_BU, 32'h0,        32'h0000_0080, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: slot full with rsp_ready low must stall and hold the response.
        idle_cycle();
        drive_req(1'b1, 1'b0, 32'h10, SZ_W, 32'h0);
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drive_req(1'b1, 1'b1, 32'h10, SZ_W, 32'h0BADF00D);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_output("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check_output("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check_output("bp_rdata", bus.rsp_rdata, 32'h80ADBEEF);
            check_output("bp_err", 32'(bus.rsp_err), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check_output("bp_release_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check_output("b2b_sw_valid", 32'(bus.rsp_valid), 32'd1);
        check_output("b2b_sw_rdata", bus.rsp_rdata, 32'h0);
        drive_req(1'b1, 1'b0, 32'h10, SZ_W, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_output("b2b_lw_valid", 32'(bus.rsp_valid), 32'd1);
        check_output("b2b_lw_rdata", bus.rsp_rdata, 32'h0BADF00D);
        @(posedge clk);
        @(negedge clk);
        check_output("b2b_drain_valid", 32'(bus.rsp_valid), 32'd0);

        // Reset with a full slot and a store on the bus: both must vanish.
        drive_req(1'b1, 1'b0, 32'h10, SZ_W, 32'h0);
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("rstfull_pre_valid", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        drive_req(1'b1, 1'b1, 32'h10, SZ_W, 32'h12345678);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        check_output("rstfull_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("rstfull_rdata", bus.rsp_rdata, 32'h0);
        check_output("rstfull_err", 32'(bus.rsp_err), 32'd0);
        v = '{1'b0, 32'h10, SZ_W, 32'h0, 32'h0BADF00D, 1'b0};
        apply_stimulus(v, "rst_store_dropped");

`ifdef DMEM_PARITY_EN
        bus.par_inject = 1'b1;
        v = '{1'b1, 32'h20, SZ_W, 32'hA5A5A5A5, 32'h0, 1'b0};
        apply_stimulus(v, "par_sw_inject");
        bus.par_inject = 1'b0;
        v = '{1'b0, 32'h21, SZ_BU, 32'h0, 32'h0000_00A5, 1'b1};
        apply_stimulus(v, "par_lbu_bad");
        v = '{1'b1, 32'h24, SZ_W, 32'h5A5A5A5A, 32'h0, 1'b0};
        apply_stimulus(v, "par_sw_clean");
        v = '{1'b0, 32'h24, SZ_BU, 32'h0, 32'h0000_005A, 1'b0};
        apply_stimulus(v, "par_lbu_clean");
`endif

        // Fill every word so the model knows the whole RAM, then random traffic.
        idle_cycle();
        for (int w = 0; w < int'(DEPTH); w++) begin
            run_cycle(1'b1, 1'b1, BASE_ADDR + 32'(w * 4), SZ_W, $urandom, 1'b1);
        end
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) < 8) sz = legal_sz[$urandom_range(0, 4)];
            else sz = 3'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                addr = BASE_ADDR + SPAN + 32'($urandom_range(0, 64));
            end else begin
                if ($urandom_range(0, 1) == 0) addr = BASE_ADDR + 32'($urandom_range(0, 63));
                else addr = BASE_ADDR + 32'($urandom_range(0, SPAN - 1));
                if ($urandom_range(0, 3) != 0) begin
                    if (sz[1:0] == 2'b10) addr[1:0] = 2'b00;
                    else if (sz[1:0] == 2'b01) addr[0] = 1'b0;
                end
            end
            we = 1'($urandom_range(0, 1));
            run_cycle(($urandom_range(0, 3) != 0), we, addr, sz, $urandom,
                      ($urandom_range(0, 3) != 0));
        end
        repeat (3) run_cycle(1'b0, 1'b0, 32'h0, SZ_W, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
